// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, single-entry fetch register and valid/ready hand-off to decode.
// Optional perf counters (fetch_count, stall_count) are built when FETCH_PERF_EN is defined.
module fetch_unit #(
    parameter int unsigned               INS_ADDRESS = 32,
    parameter int unsigned               INS_W       = 32,
    parameter logic [INS_ADDRESS-1:0]    RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_en,
    output logic [INS_ADDRESS-1:0] imem_addr,
    input  logic [INS_W-1:0]       imem_instr,
    input  logic                   redirect,
    input  logic [INS_ADDRESS-1:0] redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INS_W-1:0]       out_instr,
`ifdef FETCH_PERF_EN
    output logic [31:0]            fetch_count,
    output logic [31:0]            stall_count,
    output logic [INS_ADDRESS-1:0] out_pc
`else
    output logic [INS_ADDRESS-1:0] out_pc
`endif
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e                 state_q, state_d;
    logic [INS_ADDRESS-1:0] pc_q, pc_d;
    logic                   valid_q, valid_d;
    logic [INS_W-1:0]       instr_q, instr_d;
    logic [INS_ADDRESS-1:0] outpc_q, outpc_d;
    logic                   load;
    logic                   unused_redirect_lsbs;

    // The target's byte offset is dropped; instructions are always word aligned.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign load = (state_q == RUN) & fetch_en & ~redirect & (~valid_q | out_ready);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        outpc_d = outpc_q;

        if (state_q == IDLE && fetch_en) begin
            state_d = RUN;
        end else if (state_q == RUN && !fetch_en) begin
            state_d = IDLE;
        end

        // Redirect wins over capture and flushes the word even if decode takes it this cycle.
        if (redirect) begin
            pc_d    = {redirect_pc[INS_ADDRESS-1:2], 2'b00};
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = imem_instr;
            outpc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + INS_ADDRESS'(4);
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            outpc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            outpc_q <= outpc_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, stall_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (valid_q && out_ready) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (valid_q && !out_ready) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

    assign imem_addr = {2'b00, pc_q[INS_ADDRESS-1:2]};
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = outpc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance at RESET_PC=0 for the main scenarios,
// a second at RESET_PC=0xFFFFFFFC for pc wrap-around.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetchEn;
    logic        outReady;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] imemAddr;
    logic [31:0] imemInstr;
    logic        outValid;
    logic [31:0] outInstr;
    logic [31:0] outPc;

    logic        wrapReady;
    logic        wrapRedirect;
    logic [31:0] wrapRedirectPc;
    logic [31:0] wrapImemAddr;
    logic [31:0] wrapImemInstr;
    logic        wrapValid;
    logic [31:0] wrapInstr;
    logic [31:0] wrapPc;

`ifdef FETCH_PERF_EN
    logic [31:0] fetchCount, stallCount;
    logic [31:0] wrapFetchCount, wrapStallCount;
`endif

    int vectorCount = 0;
    int miscompareCount = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word i holds i+100.
    assign imemInstr     = imemAddr + 32'd100;
    assign wrapImemInstr = wrapImemAddr + 32'd100;

    fetch_unit #(.INS_ADDRESS(32), .INS_W(32), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetchEn),
        .imem_addr  (imemAddr),
        .imem_instr (imemInstr),
        .redirect   (redirect),
        .redirect_pc(redirectPc),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_instr  (outInstr),
`ifdef FETCH_PERF_EN
        .fetch_count(fetchCount),
        .stall_count(stallCount),
`endif
        .out_pc     (outPc)
    );

    fetch_unit #(.INS_ADDRESS(32), .INS_W(32), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetchEn),
        .imem_addr  (wrapImemAddr),
        .imem_instr (wrapImemInstr),
        .redirect   (wrapRedirect),
        .redirect_pc(wrapRedirectPc),
        .out_valid  (wrapValid),
        .out_ready  (wrapReady),
        .out_instr  (wrapInstr),
`ifdef FETCH_PERF_EN
        .fetch_count(wrapFetchCount),
        .stall_count(wrapStallCount),
`endif
        .out_pc     (wrapPc)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input logic en, input logic ready, input logic redir,
                                 input logic [31:0] rpc);
        fetchEn    = en;
        outReady   = ready;
        redirect   = redir;
        redirectPc = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        fetchEn        = 1'b0;
        outReady       = 1'b1;
        redirect       = 1'b0;
        redirectPc     = '0;
        wrapReady      = 1'b1;
        wrapRedirect   = 1'b0;
        wrapRedirectPc = '0;

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("reset_valid", {31'b0, outValid}, 32'd0);
        checkOutput("reset_pc", outPc, 32'd0);
        checkOutput("reset_instr", outInstr, 32'd0);
        checkOutput("reset_addr", imemAddr, 32'd0);
        checkOutput("wrap_reset_addr", wrapImemAddr, 32'h3FFF_FFFF);

        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("start_bubble", {31'b0, outValid}, 32'd0);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("first_valid", {31'b0, outValid}, 32'd1);
        checkOutput("first_pc", outPc, 32'd0);
        checkOutput("first_instr", outInstr, 32'd100);
        checkOutput("wrap_first_pc", wrapPc, 32'hFFFF_FFFC);
        checkOutput("wrap_first_instr", wrapInstr, 32'h4000_0063);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("second_pc", outPc, 32'd4);
        checkOutput("second_instr", outInstr, 32'd101);
        checkOutput("wrap_second_pc", wrapPc, 32'h0);
        checkOutput("wrap_second_instr", wrapInstr, 32'd100);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("third_pc", outPc, 32'd8);
        checkOutput("third_instr", outInstr, 32'd102);
        checkOutput("third_addr", imemAddr, 32'd3);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput("stall_valid", {31'b0, outValid}, 32'd1);
            checkOutput("stall_pc", outPc, 32'd8);
            checkOutput("stall_instr", outInstr, 32'd102);
            checkOutput("stall_addr", imemAddr, 32'd3);
        end
`ifdef FETCH_PERF_EN
        checkOutput("stall_count", stallCount, 32'd3);
`endif

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("release_pc", outPc, 32'd12);
        checkOutput("release_instr", outInstr, 32'd103);
`ifdef FETCH_PERF_EN
        checkOutput("fetch_count", fetchCount, 32'd3);
`endif

        applyStimulus(1'b1, 1'b1, 1'b1, 32'h41);
        checkOutput("redirect_flush", {31'b0, outValid}, 32'd0);
        checkOutput("redirect_addr", imemAddr, 32'd16);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("target_valid", {31'b0, outValid}, 32'd1);
        checkOutput("target_pc", outPc, 32'h40);
        checkOutput("target_instr", outInstr, 32'd116);
        checkOutput("target_addr", imemAddr, 32'd17);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("stop_hold_valid", {31'b0, outValid}, 32'd1);
        checkOutput("stop_hold_pc", outPc, 32'h40);
        checkOutput("stop_hold_addr", imemAddr, 32'd17);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("stop_drain_valid", {31'b0, outValid}, 32'd0);
        checkOutput("stop_drain_pc", outPc, 32'h40);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("stop_frozen_addr", imemAddr, 32'd17);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("restart_pc", outPc, 32'h44);
        checkOutput("restart_instr", outInstr, 32'd117);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("midreset_valid", {31'b0, outValid}, 32'd0);
        checkOutput("midreset_addr", imemAddr, 32'd0);
        checkOutput("midreset_pc", outPc, 32'd0);
        checkOutput("midreset_instr", outInstr, 32'd0);
`ifdef FETCH_PERF_EN
        checkOutput("midreset_fetch_count", fetchCount, 32'd0);
        checkOutput("midreset_stall_count", stallCount, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
